vga_layer_compositor: RTL

- Parametrised successor to the single-sprite top-level VGA path. It generates VGA timing from board_clk through an internal pixel clock-enable.
- It composites NUM_RECT independently programmable rectangles (bird, pipes, HUD) with fixed priority. Output is 3-bit RGB.
- Rectangle attributes are written through a valid/ready port into shadow registers. They are committed atomically at the start of vertical blank, so the image never tears.
- Sits between game logic (obstacle/flight FSMs) and the VGA pins.

---
 rtl/vga_layer_compositor_if.sv | 20 ++
 rtl/vga_layer_compositor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_layer_compositor_if.sv
// vga_layer_compositor_if: valid/ready channel carrying one rectangle's attributes.
interface vga_layer_compositor_if #(
    parameter int IDX_W = 4
);
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_idx;
    logic [9:0]       wr_x_l, wr_x_r, wr_y_t, wr_y_b;
    logic [2:0]       wr_color;
    logic             wr_en;

    modport master (
        output wr_valid, wr_idx, wr_x_l, wr_x_r, wr_y_t, wr_y_b, wr_color, wr_en,
        input  wr_ready
    );
    modport slave (
        input  wr_valid, wr_idx, wr_x_l, wr_x_r, wr_y_t, wr_y_b, wr_color, wr_en,
        output wr_ready
    );
endinterface

// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: VGA timing plus NUM_RECT fixed-priority rectangles, committed at vblank.
// Optional VGA_LAYER_COLLISION_EN adds a sticky channel-0-versus-others overlap flag.
module vga_layer_compositor #(
    parameter int         NUM_RECT = 8,
    parameter int         IDX_W    = 4,
    parameter int         PIX_DIV  = 2,
    parameter int         H_ACTIVE = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACTIVE = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    vga_layer_compositor_if.slave wr,
    output logic                  vga_h_sync,
    output logic                  vga_v_sync,
    output logic                  vga_r,
    output logic                  vga_g,
    output logic                  vga_b,
    output logic [9:0]            counter_x,
    output logic [9:0]            counter_y,
    output logic                  in_display,
    output logic                  frame_start
`ifdef VGA_LAYER_COLLISION_EN
    ,
    output logic                  collision,
    input  logic                  collision_clr
`endif
);
    localparam int               DIV_W    = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       V_CMT    = 10'(V_ACTIVE - 1);
    localparam logic [9:0]       HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic [9:0] x_l;
        logic [9:0] x_r;
        logic [9:0] y_t;
        logic [9:0] y_b;
        logic [2:0] color;
        logic       en;
    } rect_t;

    logic [DIV_W-1:0]    div_q, div_d;
    logic [9:0]          cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    rect_t               shd_q [NUM_RECT];
    rect_t               shd_d [NUM_RECT];
    rect_t               act_q [NUM_RECT];
    rect_t               act_d [NUM_RECT];
    logic [NUM_RECT-1:0] hit_q, hit_d;
    logic                act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [2:0]          rgb_q, rgb_d, sel;
    logic                pix_ce, x_wrap, commit;
    logic [IDX_W-1:0]    idx;
    rect_t               wr_rect;

    assign idx = wr.wr_idx;

    always_comb begin
        pix_ce      = div_q == DIV_LAST;
        x_wrap      = cnt_x_q == H_LAST;
        commit      = pix_ce & x_wrap & (cnt_y_q == V_CMT);
        div_d       = pix_ce ? '0 : div_q + 1'b1;
        cnt_x_d     = pix_ce ? (x_wrap ? '0 : cnt_x_q + 10'd1) : cnt_x_q;
        cnt_y_d     = (pix_ce & x_wrap) ? (cnt_y_q == V_LAST ? '0 : cnt_y_q + 10'd1) : cnt_y_q;
        in_display  = (cnt_x_q < H_ACT) & (cnt_y_q < V_ACT);
        wr.wr_ready = ~commit;
        frame_start = commit;
    end

    // Writes are refused in the commit cycle, so shadow and active never update together.
    always_comb begin
        wr_rect = {wr.wr_x_l, wr.wr_x_r, wr.wr_y_t, wr.wr_y_b, wr.wr_color, wr.wr_en};
        for (int i = 0; i < NUM_RECT; i++) begin
            shd_d[i] = (wr.wr_valid & ~commit & (32'(idx) == i)) ? wr_rect : shd_q[i];
            act_d[i] = commit ? shd_q[i] : act_q[i];
        end
    end

    always_comb begin
        hit_d = hit_q;
        for (int i = 0; i < NUM_RECT; i++)
            if (pix_ce)
                hit_d[i] = act_q[i].en & (act_q[i].x_l <= cnt_x_q) & (cnt_x_q <= act_q[i].x_r)
                         & (act_q[i].y_t <= cnt_y_q) & (cnt_y_q <= act_q[i].y_b);
        sel = BG_COLOR;
        for (int i = NUM_RECT - 1; i >= 0; i--)
            if (hit_q[i]) sel = act_q[i].color;
        act1_d = pix_ce ? in_display : act1_q;
        hs1_d  = pix_ce ? ~((cnt_x_q >= HS_BEG) & (cnt_x_q <= HS_END)) : hs1_q;
        vs1_d  = pix_ce ? ~((cnt_y_q >= VS_BEG) & (cnt_y_q <= VS_END)) : vs1_q;
        hs2_d  = pix_ce ? hs1_q : hs2_q;
        vs2_d  = pix_ce ? vs1_q : vs2_q;
        rgb_d  = pix_ce ? (act1_q ? sel : 3'b000) : rgb_q;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            div_q   <= '0;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            shd_q   <= '{default: '0};
            act_q   <= '{default: '0};
            hit_q   <= '0;
            act1_q  <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            rgb_q   <= 3'b000;
        end else begin
            div_q   <= div_d;
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
            shd_q   <= shd_d;
            act_q   <= act_d;
            hit_q   <= hit_d;
            act1_q  <= act1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            rgb_q   <= rgb_d;
        end
    end

    assign counter_x             = cnt_x_q;
    assign counter_y             = cnt_y_q;
    assign vga_h_sync            = hs2_q;
    assign vga_v_sync            = vs2_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;

`ifdef VGA_LAYER_COLLISION_EN
    logic coll_q, coll_d;

    // Setting wins over clearing so an overlap seen in the clear cycle is not lost.
    always_comb
        coll_d = (pix_ce & act1_q & hit_q[0] & |(hit_q >> 1)) ? 1'b1 : (collision_clr ? 1'b0 : coll_q);

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) coll_q <= 1'b0;
        else       coll_q <= coll_d;
    end

    assign collision = coll_q;
`endif
endmodule
